// File: rtl/key_sched_state_guard.sv
// key_sched_state_guard
//   Key-scheduled present-state register for a locked benchmark FSM. It sits
//   between the FSM's combinational next-state logic and its state register.
//   A rolling schedule of NUM_KEYS windows, each WINDOW_LEN cycles long,
//   selects which key is expected on each edge. When the applied key matches
//   the key for the current window, nx_state is loaded. Otherwise that
//   window's decoy state is loaded. With STICKY=1, the first mismatch latches
//   a lockout that persists until reset.
//
// Ports
//   clk       in   1        clock, all updates on the falling edge
//   rst       in   1        asynchronous active-high reset
//   keyinput  in   KEY_W    applied key, compared as a full vector
//   nx_state  in   STATE_W  next state from the FSM core logic
//   pr_state  out  STATE_W  registered present state
//   locked    out  1        sticky lockout flag (always 0 when STICKY=0)
module key_sched_state_guard #(
    parameter int                            STATE_W     = 5,
    parameter int                            KEY_W       = 7,
    parameter int                            NUM_KEYS    = 2,
    parameter int                            WINDOW_LEN  = 7,
    parameter logic [NUM_KEYS*KEY_W-1:0]     KEY_TABLE   = {7'h0B, 7'h42},
    parameter logic [NUM_KEYS*STATE_W-1:0]   DECOY_TABLE = {5'd9, 5'd7},
    parameter logic [STATE_W-1:0]            RESET_STATE = 5'd1,
    parameter bit                            STICKY      = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   keyinput,
    input  logic [STATE_W-1:0] nx_state,
    output logic [STATE_W-1:0] pr_state,
    output logic               locked
);

    localparam int PERIOD = NUM_KEYS * WINDOW_LEN;
    // Keep both counters at least one bit wide so that a degenerate
    // single-cycle schedule still elaborates.
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int WW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic [CW-1:0]      cnt;
    logic [WW-1:0]      win;
    logic [KEY_W-1:0]   cur_key;
    logic [STATE_W-1:0] cur_decoy;
    logic               key_ok;
    logic               match;

    // The window index comes from the pre-edge count. The division is
    // done in int so that WINDOW_LEN is never truncated to CW bits.
    always_comb begin
        win       = WW'(int'(cnt) / WINDOW_LEN);
        cur_key   = KEY_TABLE[KEY_W-1:0];
        cur_decoy = DECOY_TABLE[STATE_W-1:0];
        for (int i = 1; i < NUM_KEYS; i++) begin
            if (win == WW'(i)) begin
                cur_key   = KEY_TABLE[i*KEY_W +: KEY_W];
                cur_decoy = DECOY_TABLE[i*STATE_W +: STATE_W];
            end
        end
        key_ok = (keyinput == cur_key);
        match  = key_ok && !locked;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            pr_state <= RESET_STATE;
            locked   <= 1'b0;
        end else begin
            cnt      <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + CW'(1);
            pr_state <= match ? nx_state : cur_decoy;
            // Once set, the lockout is cleared only by reset.
            if (STICKY && !key_ok) begin
                locked <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_sched_state_guard.sv
`timescale 1ns/1ps
module tb_key_sched_state_guard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] ka, kb, kc;
    logic [4:0] nxa, nxb, nxc;
    logic [4:0] pra, prb, prc;
    logic       lka, lkb, lkc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // A: default configuration.
    key_sched_state_guard dut_a (
        .clk(clk), .rst(rst), .keyinput(ka), .nx_state(nxa),
        .pr_state(pra), .locked(lka)
    );

    // B: default configuration with sticky lockout.
    key_sched_state_guard #(.STICKY(1'b1)) dut_b (
        .clk(clk), .rst(rst), .keyinput(kb), .nx_state(nxb),
        .pr_state(prb), .locked(lkb)
    );

    // C: three one-cycle windows.
    key_sched_state_guard #(
        .NUM_KEYS(3), .WINDOW_LEN(1),
        .KEY_TABLE({7'h03, 7'h02, 7'h01}),
        .DECOY_TABLE({5'd6, 5'd5, 5'd4})
    ) dut_c (
        .clk(clk), .rst(rst), .keyinput(kc), .nx_state(nxc),
        .pr_state(prc), .locked(lkc)
    );

    // The reference model counts edges since reset and maps them onto the schedule arithmetically.
    int         n;
    logic [4:0] exp_a, exp_b, exp_c;
    bit         lock_b;

    function automatic logic [6:0] key_def(int e);
        return (((e % 14) / 7) == 0) ? 7'h42 : 7'h0B;
    endfunction
    function automatic logic [4:0] decoy_def(int e);
        return (((e % 14) / 7) == 0) ? 5'd7 : 5'd9;
    endfunction
    function automatic logic [6:0] key_c(int e);
        return 7'((e % 3) + 1);
    endfunction
    function automatic logic [4:0] decoy_c(int e);
        return 5'((e % 3) + 4);
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        chk("pr_a", 7'(pra), 7'(exp_a));
        chk("pr_b", 7'(prb), 7'(exp_b));
        chk("pr_c", 7'(prc), 7'(exp_c));
        chk("lk_a", 7'(lka), 7'd0);
        chk("lk_b", 7'(lkb), 7'(lock_b));
        chk("lk_c", 7'(lkc), 7'd0);
    endtask

    // Advance one falling edge using the inputs currently applied, then sample on the following rising edge.
    task automatic tick();
        exp_a = (ka == key_def(n)) ? nxa : decoy_def(n);
        exp_b = (!lock_b && kb == key_def(n)) ? nxb : decoy_def(n);
        if (kb != key_def(n)) lock_b = 1'b1;
        exp_c = (kc == key_c(n)) ? nxc : decoy_c(n);
        n++;
        @(negedge clk);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between edges; outputs must change without a clock edge.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        exp_a = 5'd1; exp_b = 5'd1; exp_c = 5'd1; lock_b = 1'b0; n = 0;
        check_all();
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [6:0] pick(logic [6:0] good);
        return ($urandom_range(0, 9) < 7) ? good : 7'($urandom);
    endfunction

    initial begin
        ka = 7'h42; kb = 7'h42; kc = 7'h01;
        nxa = 5'd3; nxb = 5'd3; nxc = 5'd3;
        exp_a = 5'd1; exp_b = 5'd1; exp_c = 5'd1; lock_b = 1'b0; n = 0;

        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Correct key for each window, so every edge passes nx_state.
        for (int i = 0; i < 14; i++) begin
            ka = key_def(n); kb = key_def(n); nxa = 5'd3; nxb = 5'd3;
            kc = (n % 3 == 2) ? 7'h00 : key_c(n); nxc = 5'($urandom);
            tick();
            chk("pass_a", 7'(pra), 7'd3);
        end

        // Key 0x42 held constant, so window 1 yields decoy 9; then the schedule wraps.
        for (int i = 0; i < 16; i++) begin
            ka = 7'h42; nxa = 5'd3;
            kb = key_def(n); nxb = 5'($urandom);
            kc = key_c(n); nxc = 5'($urandom);
            tick();
            chk("const_key_a", 7'(pra), (i < 7 || i >= 14) ? 7'd3 : 7'd9);
        end

        // Sticky lockout caused by a single wrong key at cnt=3.
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            kb = (i == 3) ? 7'h55 : key_def(n); nxb = 5'd3;
            ka = key_def(n); nxa = 5'($urandom);
            kc = pick(key_c(n)); nxc = 5'($urandom);
            tick();
            chk("sticky_b", 7'(prb), (i < 3) ? 7'd3 : 7'(decoy_def(i)));
        end

        // Non-sticky: one wrong edge gives the decoy, then normal flow resumes.
        ka = 7'h00; nxa = 5'd12; tick();
        chk("one_wrong_a", 7'(pra), 7'(decoy_def(n - 1)));
        ka = key_def(n); nxa = 5'd12; tick();
        chk("recover_a", 7'(pra), 7'd12);

        // Reset mid-window at cnt=10; the first edge after release expects key 0x42.
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            ka = key_def(n); kb = key_def(n); kc = key_c(n); tick();
        end
        pulse_reset();
        ka = 7'h42; nxa = 5'd20; kb = 7'h0B; nxb = 5'd20; kc = 7'h01; nxc = 5'd20;
        tick();
        chk("post_rst_a", 7'(pra), 7'd20);
        chk("post_rst_b", 7'(prb), 7'd7);

        // Randomized stimulus with occasional resets.
        for (int i = 0; i < 300; i++) begin
            if (i % 45 == 44) pulse_reset();
            ka = pick(key_def(n)); nxa = 5'($urandom);
            kb = ($urandom_range(0, 19) == 0) ? 7'($urandom) : key_def(n);
            nxb = 5'($urandom);
            kc = pick(key_c(n)); nxc = 5'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
